// File: rtl/icache_fill_ctrl_if.sv
// Bus bundle for the I-cache fill controller: fetch-side request, cache
// hit/miss flags, memory read port, assembled fill block and perf counters.
// The master modport is the controller's view; the slave modport is the
// environment's view (cache + fetch stage + memory).
interface icache_fill_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    // fetch stage / cache lookup
    logic [31:0]          pc;
    logic                 pc_valid;
    logic                 hit;
    logic                 miss;
    // instruction memory read port
    logic [31:0]          mem_addr;
    logic                 mem_rd_en;
    logic [31:0]          mem_rdata;
    logic                 mem_valid;
    // fill block, w0 is the lowest address
    logic [31:0]          w0;
    logic [31:0]          w1;
    logic [31:0]          w2;
    logic [31:0]          w3;
    logic [31:0]          w4;
    logic [31:0]          w5;
    logic [31:0]          w6;
    logic [31:0]          w7;
    // cache write strobe and pipeline hold
    logic                 update;
    logic                 stall;
    // performance counters
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;

    modport master (
        input  pc, pc_valid, hit, miss, mem_rdata, mem_valid,
        output mem_addr, mem_rd_en,
        output w0, w1, w2, w3, w4, w5, w6, w7,
        output update, stall, hit_count, miss_count
    );

    modport slave (
        output pc, pc_valid, hit, miss, mem_rdata, mem_valid,
        input  mem_addr, mem_rd_en,
        input  w0, w1, w2, w3, w4, w5, w6, w7,
        input  update, stall, hit_count, miss_count
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Miss-handling controller for a 16-set, 8-word-block direct-mapped I-cache.
// On a fetch miss it stalls the CPU, reads the 8-word block one word at a
// time from instruction memory, then pulses update for one cycle so the cache
// can write the line. Also keeps saturating hit/miss counters.
module icache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    icache_fill_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    // word index of the last word in a block
    localparam logic [2:0] LAST_K = 3'(BLOCK_WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_k;
    logic [31:0]          r_base;
    logic [31:0]          r_words [BLOCK_WORDS];
    logic [CNT_WIDTH-1:0] r_hit_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;

    logic                 w_miss_go;
    logic                 w_hit_go;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_stall;
    logic                 w_rd_en;
    logic                 w_update;

    // decoded events; a lookup only counts in IDLE, miss wins over hit
    assign w_miss_go = (r_state == S_IDLE) && bus.pc_valid && bus.miss;
    assign w_hit_go  = (r_state == S_IDLE) && bus.pc_valid && bus.hit && !bus.miss;
    assign w_accept  = (r_state == S_FETCH) && bus.mem_valid;
    assign w_last    = (r_k == LAST_K);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_miss_go)           w_next = S_FETCH;
            S_FETCH:  if (w_accept && w_last)  w_next = S_UPDATE;
            S_UPDATE:                          w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs; IDLE stall is combinational so the miss cycle itself holds the PC
    always_comb begin
        w_stall  = 1'b0;
        w_rd_en  = 1'b0;
        w_update = 1'b0;
        case (r_state)
            S_IDLE:   w_stall = bus.pc_valid && bus.miss;
            S_FETCH:  begin w_stall = 1'b1; w_rd_en  = 1'b1; end
            S_UPDATE: begin w_stall = 1'b1; w_update = 1'b1; end
            default:  ;
        endcase
    end

    // block base and word pointer; base is the 32-byte aligned miss address
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_base <= 32'd0;
            r_k    <= 3'd0;
        end else if (w_miss_go) begin
            r_base <= bus.pc & ~32'h1F;
            r_k    <= 3'd0;
        end else if (w_accept && !w_last) begin
            r_k    <= r_k + 3'd1;
        end
    end

    // capture returned words into the slot selected by k
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BLOCK_WORDS; i++) r_words[i] <= 32'd0;
        end else if (w_accept) begin
            for (int i = 0; i < BLOCK_WORDS; i++)
                if (r_k == 3'(i)) r_words[i] <= bus.mem_rdata;
        end
    end

    // saturating performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_miss_go && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
            if (w_hit_go  && (r_hit_cnt  != '1)) r_hit_cnt  <= r_hit_cnt  + 1'b1;
        end
    end

    // 3-bit k keeps the address inside the 32-byte block
    assign bus.mem_addr   = r_base + {27'd0, r_k, 2'b00};
    assign bus.mem_rd_en  = w_rd_en;
    assign bus.stall      = w_stall;
    assign bus.update     = w_update;
    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;
    assign bus.w0         = r_words[0];
    assign bus.w1         = r_words[1];
    assign bus.w2         = r_words[2];
    assign bus.w3         = r_words[3];
    assign bus.w4         = r_words[4];
    assign bus.w5         = r_words[5];
    assign bus.w6         = r_words[6];
    assign bus.w7         = r_words[7];

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Scoreboard bench for icache_fill_ctrl: stimulus pushes expected memory
// addresses and expected fill blocks; a negedge monitor pops and compares
// whenever the DUT accepts a word or pulses update.
module tb_icache_fill_ctrl;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    icache_fill_ctrl_if #(.CNT_WIDTH(32)) bus ();
    icache_fill_ctrl #(.BLOCK_WORDS(8), .CNT_WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    // narrow-counter build for the saturation case
    icache_fill_ctrl_if #(.CNT_WIDTH(4)) bus4 ();
    icache_fill_ctrl #(.BLOCK_WORDS(8), .CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .bus(bus4)
    );

    int checks   = 0;
    int failures = 0;
    int stall_cyc = 0;

    logic [31:0]  addr_q[$];
    logic [255:0] blk_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] mk_blk(input logic [31:0] d0);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = d0 + 32'(i);
        return b;
    endfunction

    // monitor: compares accepted-word addresses and update-time blocks
    always @(negedge CLK) begin
        if (RST !== 1'b1) begin
            if (bus.stall) stall_cyc++;
            if (bus.mem_rd_en && bus.mem_valid) begin
                if (addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_accept: addr %h with empty queue", bus.mem_addr);
                end else begin
                    chk("mem_addr_accept", bus.mem_addr, addr_q.pop_front());
                end
            end
            if (bus.update) begin
                if (blk_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_update: update=1 with no fill expected");
                end else begin
                    logic [255:0] got, exp;
                    got = {bus.w7, bus.w6, bus.w5, bus.w4, bus.w3, bus.w2, bus.w1, bus.w0};
                    exp = blk_q.pop_front();
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL fill_block: got %h expected %h", got, exp);
                    end
                end
            end
        end
    end

    // serve nw words from memory; word slow_idx takes slow_lat cycles, others 1
    task automatic fill(input logic [31:0] base, input logic [31:0] d0, input int nw,
                        input int slow_idx, input int slow_lat, input logic [31:0] pc_alt);
        for (int i = 0; i < nw; i++) begin
            int lat;
            lat = (i == slow_idx) ? slow_lat : 1;
            addr_q.push_back(base + 32'(4 * i));
            for (int j = 0; j < lat - 1; j++) begin
                bus.mem_valid = 1'b0;
                tick();
                chk("hold_addr", bus.mem_addr, base + 32'(4 * i));
                chk("hold_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
            end
            bus.mem_valid = 1'b1;
            bus.mem_rdata = d0 + 32'(i);
            tick();
            bus.mem_valid = 1'b0;
            if (i == 0) bus.pc = pc_alt;
        end
    endtask

    task automatic chk_words_zero();
        chk("w0_zero", bus.w0, 32'd0); chk("w1_zero", bus.w1, 32'd0);
        chk("w2_zero", bus.w2, 32'd0); chk("w3_zero", bus.w3, 32'd0);
        chk("w4_zero", bus.w4, 32'd0); chk("w5_zero", bus.w5, 32'd0);
        chk("w6_zero", bus.w6, 32'd0); chk("w7_zero", bus.w7, 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        bus.pc = 32'd0;  bus.pc_valid = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0;
        bus.mem_rdata = 32'd0; bus.mem_valid = 1'b0;
        bus4.pc = 32'd0; bus4.pc_valid = 1'b0; bus4.hit = 1'b0; bus4.miss = 1'b0;
        bus4.mem_rdata = 32'd0; bus4.mem_valid = 1'b0;
        tick(); tick();
        RST = 1'b0;

        // reset state
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("rst_update", {31'd0, bus.update}, 32'd0);
        chk("rst_hit_cnt", bus.hit_count, 32'd0);
        chk("rst_miss_cnt", bus.miss_count, 32'd0);
        chk_words_zero();

        // miss at 0x100, 1-cycle memory
        bus.pc = 32'h0000_0100; bus.pc_valid = 1'b1; bus.miss = 1'b1;
        #1;
        chk("miss_stall_same_cycle", {31'd0, bus.stall}, 32'd1);
        chk("miss_no_rd_yet", {31'd0, bus.mem_rd_en}, 32'd0);
        tick();
        stall_cyc = 0;
        chk("fetch_addr0", bus.mem_addr, 32'h100);
        chk("fetch_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
        chk("miss_cnt_1", bus.miss_count, 32'd1);
        blk_q.push_back(mk_blk(32'hA0));
        fill(32'h100, 32'hA0, 8, -1, 1, 32'h0000_0100);
        chk("upd_pulse", {31'd0, bus.update}, 32'd1);
        chk("upd_stall", {31'd0, bus.stall}, 32'd1);
        chk("upd_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        bus.miss = 1'b0; bus.hit = 1'b1;
        tick();
        chk("post_upd_update", {31'd0, bus.update}, 32'd0);
        chk("post_upd_stall", {31'd0, bus.stall}, 32'd0);
        chk("penalty_1lat", stall_cyc, 32'd9);
        tick();  // IDLE hit counted
        bus.pc_valid = 1'b0; bus.hit = 1'b0;
        tick();
        chk("hit_cnt_1", bus.hit_count, 32'd1);

        // variable latency on word 2, pc wobble mid-fill must not move the base
        bus.pc = 32'h0000_2040; bus.pc_valid = 1'b1; bus.miss = 1'b1;
        tick();
        stall_cyc = 0;
        chk("fetch2_addr0", bus.mem_addr, 32'h2040);
        chk("miss_cnt_2", bus.miss_count, 32'd2);
        blk_q.push_back(mk_blk(32'hB0));
        fill(32'h2040, 32'hB0, 8, 2, 3, 32'hDEAD_0000);
        chk("upd2_pulse", {31'd0, bus.update}, 32'd1);
        bus.pc = 32'h0000_2040; bus.miss = 1'b0; bus.hit = 1'b1;
        tick();
        chk("penalty_slow", stall_cyc, 32'd11);
        chk("w2_slow", bus.w2, 32'hB2);
        chk("post_upd2_stall", {31'd0, bus.stall}, 32'd0);
        bus.pc_valid = 1'b0; bus.hit = 1'b0;

        // reset during FETCH at k=4
        bus.pc = 32'h0000_0300; bus.pc_valid = 1'b1; bus.miss = 1'b1;
        tick();
        bus.pc_valid = 1'b0; bus.miss = 1'b0;
        fill(32'h300, 32'hC0, 4, -1, 1, 32'h0000_0300);
        chk("k4_addr", bus.mem_addr, 32'h310);
        chk("k4_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        chk("abort_update", {31'd0, bus.update}, 32'd0);
        chk("abort_hit_cnt", bus.hit_count, 32'd0);
        chk("abort_miss_cnt", bus.miss_count, 32'd0);
        chk_words_zero();
        bus.mem_valid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        chk("stray_valid_w0", bus.w0, 32'd0);
        chk("stray_valid_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("stray_valid_update", {31'd0, bus.update}, 32'd0);
        bus.mem_valid = 1'b0;

        // 5 hits then 3 idle cycles
        bus.pc = 32'h0000_2040;
        for (int i = 0; i < 5; i++) begin
            bus.pc_valid = 1'b1; bus.hit = 1'b1;
            #1;
            chk("hit_run_stall", {31'd0, bus.stall}, 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.pc_valid = 1'b0; bus.hit = 1'b0;
            #1;
            chk("idle_run_stall", {31'd0, bus.stall}, 32'd0);
            tick();
        end
        chk("hit_cnt_5", bus.hit_count, 32'd5);
        chk("miss_cnt_0", bus.miss_count, 32'd0);

        // saturation on the 4-bit counter build
        for (int i = 0; i < 16; i++) begin
            bus4.pc_valid = 1'b1; bus4.hit = 1'b1;
            tick();
            if (i == 14) chk("hit4_at_15", {28'd0, bus4.hit_count}, 32'hF);
        end
        bus4.pc_valid = 1'b0; bus4.hit = 1'b0;
        tick();
        chk("hit4_saturated", {28'd0, bus4.hit_count}, 32'hF);
        chk("miss4_zero", {28'd0, bus4.miss_count}, 32'h0);

        // every expected transaction consumed
        tick();
        chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
        chk("blk_q_empty", 32'(blk_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Miss-handling controller for the 16-set, 8-word-per-block direct-mapped instruction cache.
- Detects a miss on the fetch PC, stalls the CPU, and fetches the 8-word block from instruction memory one word at a time over a valid-handshake port.
- Presents the assembled block on w0..w7 and pulses update for one cycle to write the cache line.
- Sits between the cache, the PC/fetch stage and the memory port.
- Also keeps saturating hit/miss performance counters.

Parameters:
BLOCK_WORDS, 8, words per cache block; fixed at 8 to match the w0..w7 bus.
CNT_WIDTH, 32, width of the hit/miss performance counters.

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
pc  input  32  current fetch address
pc_valid  input  1  fetch stage is requesting an instruction this cycle
hit  input  1  cache hit indication (combinational from cache)
miss  input  1  cache miss indication (combinational from cache)
mem_addr  output  32  word address to instruction memory
mem_rd_en  output  1  memory read request
mem_rdata  input  32  memory read data
mem_valid  input  1  memory read data valid (variable latency, >=1 cycle)
w0..w7  output  32 each  assembled fill block, w0 = lowest address
update  output  1  one-cycle cache write strobe
stall  output  1  hold PC / fetch stage
hit_count  output  CNT_WIDTH  number of hit accesses
miss_count  output  CNT_WIDTH  number of misses serviced

Behaviour:
Reset
- On RST high at a rising edge: state=IDLE, word counter k=0, base address register=0, w0..w7=0, hit_count=0, miss_count=0.
- mem_rd_en=0, update=0. stall follows IDLE rule below.
- RST mid-fill aborts the fill with no update pulse; any pending mem_valid is ignored.

States
- IDLE
  - stall = pc_valid & miss (combinational).
  - If pc_valid & miss: latch base = {pc[31:5],5'b0}, k=0, go FETCH, increment miss_count.
  - Else if pc_valid & hit: increment hit_count.
- FETCH
  - stall=1, mem_rd_en=1, mem_addr = base + 4*k, held stable until mem_valid.
  - On mem_valid: capture mem_rdata into word k (w_k).
    - If k=7: go UPDATE.
    - Else: k=k+1.
  - One word is accepted per cycle at most. Back-to-back mem_valid on consecutive cycles gives a 9-cycle miss penalty with 1-cycle memory latency.
- UPDATE
  - stall=1, update=1 for exactly one cycle, mem_rd_en=0.
  - w0..w7 and pc unchanged, so the cache writes tag pc[31:9] at index pc[8:5].
  - Next state IDLE. The cache now reports hit, so stall drops combinationally; no extra bubble.

Rules
- mem_valid outside FETCH is ignored.
- update is never asserted outside UPDATE.
- pc must be held by the CPU while stall=1. pc changes during FETCH do not affect base (already latched).
- Counters saturate at all-ones and do not wrap.
- hit and miss both low (pc_valid=0) counts nothing.
- Address arithmetic uses a 3-bit k: base + {k,2'b00}. Never crosses the 32-byte block boundary.

Test Plan:
- Reset then pc=0x0000_0100, pc_valid=1, miss=1 -> stall=1 same cycle; next cycle FETCH, mem_addr=0x100, mem_rd_en=1; miss_count=1.
- Memory returns 0xA0..0xA7 with 1-cycle latency -> mem_addr steps 0x100..0x11C; w0=0xA0..w7=0xA7; update high exactly one cycle after 8th mem_valid; stall low the cycle after update.
- Variable latency: mem_valid delayed 3 cycles on word 2 -> mem_addr holds 0x108 and mem_rd_en stays 1 for those cycles; w2 captured correctly; total miss penalty 11 cycles.
- Assert RST during FETCH at k=4 -> next cycle IDLE, update never asserted, w0..w7=0, counters=0; a later mem_valid is ignored.
- 5 cycles pc_valid=1 with hit=1, then pc_valid=0 for 3 cycles -> hit_count=5, miss_count unchanged, stall=0 throughout.
- Preload hit_count to max (CNT_WIDTH=4 build, 15 hits) then one more hit -> hit_count stays 0xF.
